// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and default pattern shared by the pattern generator and detector
//   exports: seq_state_t (IDLE/SEND/GAP/DONE), DEF_PAT_W, DEF_PATTERN
package seq_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} seq_state_t;
    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1111;
endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: control and serial-output bundle of the pattern generator
//   master: drives start/rep_cnt/gap_len/abort, observes dout/dout_valid/frame_sof/busy/done
//   slave:  the generator side of the same signals
interface seq_pattern_gen_if #(
    parameter int REP_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             dout;
    logic             dout_valid;
    logic             frame_sof;
    logic             busy;
    logic             done;
    modport master (
        output start, abort, rep_cnt, gap_len,
        input  dout, dout_valid, frame_sof, busy, done
    );
    modport slave (
        input  start, abort, rep_cnt, gap_len,
        output dout, dout_valid, frame_sof, busy, done
    );
endinterface

// File: rtl/seq_gen_shift.sv
// seq_gen_shift: MSB-first pattern shifter with bit index and last-bit flag
//   in:  clk, reset, load (restart at bit 0), shift (advance one bit)
//   out: nxt_bit (pattern bit after the one on air), last (bit on air is the final one)
module seq_gen_shift #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic shift,
    output logic nxt_bit,
    output logic last
);
    localparam int IW = $clog2(PAT_W);
    logic [PAT_W-1:0] sr;
    logic [IW-1:0]    idx;
    // the parent puts bit 0 on air itself, so the register holds the bits still to come
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= PATTERN << 1;
            idx <= '0;
        end else if (shift) begin
            sr  <= sr << 1;
            idx <= idx + 1'b1;
        end
    end
    assign nxt_bit = sr[PAT_W-1];
    assign last    = idx == IW'(PAT_W - 1);
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: repeats a fixed pattern MSB-first on a serial line with idle gaps between frames
//   in:  clk, reset (async, active-high)
//   bus: slave side of seq_pattern_gen_if (start/rep_cnt/gap_len/abort in; dout/dout_valid/frame_sof/busy/done out)
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               REP_W   = 8,
    parameter int               GAP_W   = 4
) (
    input logic               clk,
    input logic               reset,
    seq_pattern_gen_if.slave  bus
);
    seq_state_t       state;
    logic [REP_W-1:0] rem;
    logic [GAP_W-1:0] gap_l;
    logic [GAP_W-1:0] gcnt;
    logic             go;
    logic             rearm;
    logic             load;
    logic             shift;
    logic             nxt_bit;
    logic             last;
    assign go    = bus.start && bus.rep_cnt != '0;
    assign rearm = (state == SEND && last && rem != '0 && gap_l == '0) || (state == GAP && gcnt == '0);
    assign load  = (state == IDLE && go) || (rearm && !bus.abort);
    assign shift = state == SEND && !last && !bus.abort;
    seq_gen_shift #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .nxt_bit(nxt_bit),
        .last   (last)
    );
    // rem counts repetitions still owed after the one currently on air
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rem            <= '0;
            gap_l          <= '0;
            gcnt           <= '0;
            bus.dout       <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.frame_sof  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else if (state != IDLE && bus.abort) begin
            state          <= IDLE;
            bus.dout       <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.frame_sof  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.frame_sof <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state          <= SEND;
                    rem            <= bus.rep_cnt - 1'b1;
                    gap_l          <= bus.gap_len;
                    bus.dout       <= PATTERN[PAT_W-1];
                    bus.dout_valid <= 1'b1;
                    bus.frame_sof  <= 1'b1;
                    bus.busy       <= 1'b1;
                end
                SEND: if (!last) begin
                    bus.dout <= nxt_bit;
                end else if (rem == '0) begin
                    state          <= DONE;
                    bus.dout       <= 1'b0;
                    bus.dout_valid <= 1'b0;
                    bus.done       <= 1'b1;
                end else begin
                    rem <= rem - 1'b1;
                    if (gap_l != '0) begin
                        state          <= GAP;
                        gcnt           <= gap_l - 1'b1;
                        bus.dout       <= 1'b0;
                        bus.dout_valid <= 1'b0;
                    end else begin
                        bus.dout      <= PATTERN[PAT_W-1];
                        bus.frame_sof <= 1'b1;
                    end
                end
                GAP: if (gcnt == '0) begin
                    state          <= SEND;
                    bus.dout       <= PATTERN[PAT_W-1];
                    bus.dout_valid <= 1'b1;
                    bus.frame_sof  <= 1'b1;
                end else begin
                    gcnt <= gcnt - 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
